// File: rtl/esp_fpga_pkg.sv
// Shared types and constants for the ESP query front-end.
package esp_fpga_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACK    = 2'd2
    } esp_query_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int SETTLE_DEF      = 2;
    localparam int DB_CYCLES_DEF   = 50000;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;

endpackage

// File: rtl/esp_query_ctrl_debounce.sv
// switch_debounce: one synchronized switch bit in, one registered clean bit out.
// The clean bit follows the input only after the input has differed from it
// on DB_CYCLES consecutive clock edges; any reversal restarts the window.
module switch_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_clean
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;

    // Count consecutive disagreeing cycles; adopt the new level when the window completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_clean <= 1'b0;
        end else if (i_din == r_clean) begin
            r_cnt   <= {CNT_W{1'b0}};
        end else if (r_cnt >= CNT_LAST) begin
            r_clean <= i_din;
            r_cnt   <= {CNT_W{1'b0}};
        end else if (r_cnt != CNT_MAX) begin
            r_cnt   <= r_cnt + CNT_W'(1'b1);
        end
    end

    assign o_clean = r_clean;

endmodule

// File: rtl/esp_query_ctrl.sv
// esp_query_ctrl: synchronizes ESP select/request and board switches, runs a
// four-phase req/ack handshake and holds the registered mux select.
// Optional feature macro: ESP_QUERY_DEBOUNCE_EN -- when defined each switch is
// debounced over DB_CYCLES clocks; otherwise ch_clean is the synchronized
// switch bus delayed by one register.
module esp_query_ctrl
    import esp_fpga_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int SETTLE      = SETTLE_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  esp_sel,
    input  logic              esp_req,
    input  logic [NUM_CH-1:0] ch,
    output logic [SEL_W-1:0]  sel_q,
    output logic [NUM_CH-1:0] ch_clean,
    output logic              esp_ack
);

    // One synchronizer chain carries select, request and switches side by side.
    localparam int SYNC_W = SEL_W + 1 + NUM_CH;
    localparam int CNT_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE);

    logic [SYNC_W-1:0] r_sync [SYNC_STAGES];
    logic [SEL_W-1:0]  w_sel_s;
    logic              w_req_s;
    logic [NUM_CH-1:0] w_ch_s;

    esp_query_state_t  r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SEL_W-1:0]  r_sel_q;
    logic              r_ack;

    // Multi-flop synchronizer for every asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= {SYNC_W{1'b0}};
            end
        end else begin
            r_sync[0] <= {esp_sel, esp_req, ch};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sel_s = r_sync[SYNC_STAGES-1][SYNC_W-1 -: SEL_W];
    assign w_req_s = r_sync[SYNC_STAGES-1][NUM_CH];
    assign w_ch_s  = r_sync[SYNC_STAGES-1][NUM_CH-1:0];

    // Handshake FSM: capture select on request, wait for settling, then ack until request drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= esp_fpga_pkg::IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_sel_q <= {SEL_W{1'b0}};
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                esp_fpga_pkg::IDLE: begin
                    r_ack <= 1'b0;
                    if (w_req_s) begin
                        r_sel_q <= w_sel_s;
                        r_cnt   <= CNT_INIT;
                        r_state <= esp_fpga_pkg::SETTLE;
                    end
                end
                esp_fpga_pkg::SETTLE: begin
                    if (!w_req_s) begin
                        // Aborted request: no ack, the captured select is kept.
                        r_state <= esp_fpga_pkg::IDLE;
                    end else if (r_cnt == {CNT_W{1'b0}}) begin
                        r_ack   <= 1'b1;
                        r_state <= esp_fpga_pkg::ACK;
                    end else begin
                        r_cnt   <= r_cnt - CNT_W'(1'b1);
                    end
                end
                esp_fpga_pkg::ACK: begin
                    if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= esp_fpga_pkg::IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= esp_fpga_pkg::IDLE;
                end
            endcase
        end
    end

    assign sel_q   = r_sel_q;
    assign esp_ack = r_ack;

`ifdef ESP_QUERY_DEBOUNCE_EN
    logic [NUM_CH-1:0] w_ch_clean;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_db
        switch_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .i_din   (w_ch_s[g]),
            .o_clean (w_ch_clean[g])
        );
    end

    assign ch_clean = w_ch_clean;
`else
    logic [NUM_CH-1:0] r_ch_clean;

    // Without debounce the switches are simply re-registered after synchronization.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ch_clean <= {NUM_CH{1'b0}};
        end else begin
            r_ch_clean <= w_ch_s;
        end
    end

    assign ch_clean = r_ch_clean;
`endif

endmodule

// File: tb/tb_esp_query_ctrl.sv
// Self-checking bench for esp_query_ctrl (SYNC_STAGES=2, SETTLE=2, DB_CYCLES=4).
module tb_esp_query_ctrl;

    localparam int SYNC = 2;
    localparam int STL  = 2;
    localparam int DB   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  esp_sel = 4'd0;
    logic        esp_req = 1'b0;
    logic [15:0] ch = 16'd0;
    logic [3:0]  sel_q;
    logic [15:0] ch_clean;
    logic        esp_ack;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: pin history, request run length, expected outputs.
    logic [20:0] m_hist [SYNC];
    int          m_run;
    logic [3:0]  m_sel;
    logic [15:0] m_clean;
    int          m_diff [16];

    esp_query_ctrl #(
        .SYNC_STAGES (SYNC),
        .SETTLE      (STL),
        .DB_CYCLES   (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .esp_sel  (esp_sel),
        .esp_req  (esp_req),
        .ch       (ch),
        .sel_q    (sel_q),
        .ch_clean (ch_clean),
        .esp_ack  (esp_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int val, input int lo, input int hi);
        n_cmp++;
        if (val < lo || val > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, val, lo, hi, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < SYNC; i++) m_hist[i] = 21'd0;
        m_run   = 0;
        m_sel   = 4'd0;
        m_clean = 16'd0;
        for (int i = 0; i < 16; i++) m_diff[i] = 0;
    endtask

    // One clock edge of the model: the synchronized view is the pin value SYNC edges old.
    task automatic m_edge();
        logic [20:0] pre;
        pre = m_hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = {esp_sel, esp_req, ch};
        // Request high for a run of edges: first edge captures select, ack after STL+2 edges.
        if (pre[16]) begin
            if (m_run < 1000000) m_run = m_run + 1;
            if (m_run == 1) m_sel = pre[20:17];
        end else begin
            m_run = 0;
        end
`ifdef ESP_QUERY_DEBOUNCE_EN
        for (int i = 0; i < 16; i++) begin
            if (pre[i] != m_clean[i]) begin
                m_diff[i] = m_diff[i] + 1;
                if (m_diff[i] >= DB) begin
                    m_clean[i] = pre[i];
                    m_diff[i]  = 0;
                end
            end else begin
                m_diff[i] = 0;
            end
        end
`else
        m_clean = pre[15:0];
`endif
    endtask

    // Advance one clock and compare all outputs with the model on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) m_clear();
        else m_edge();
        @(negedge clk);
        chk("sel_q", {28'd0, sel_q}, {28'd0, m_sel});
        chk("ch_clean", {16'd0, ch_clean}, {16'd0, m_clean});
        chk("esp_ack", {31'd0, esp_ack}, (m_run >= STL + 2) ? 32'd1 : 32'd0);
    endtask

    task automatic wait_ack(input logic lvl, input int lim, output int lat);
        int i;
        i = 0;
        lat = -1;
        while (lat < 0 && i < lim) begin
            i++;
            step();
            if (esp_ack === lvl) lat = i;
        end
    endtask

    initial begin
        int lat;
        int saw;
        logic bounce_mode;

        m_clear();
        // Reset held with request high and all switches on.
        reset = 1'b1;
        esp_req = 1'b1;
        ch = 16'hFFFF;
        esp_sel = 4'd0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step();
        chk("rst_sel_q", {28'd0, sel_q}, 32'd0);
        chk("rst_ch_clean", {16'd0, ch_clean}, 32'd0);
        chk("rst_ack", {31'd0, esp_ack}, 32'd0);

        // Release with request still high: a fresh transaction must follow.
        reset = 1'b0;
        wait_ack(1'b1, 20, lat);
        chk_range("ack_lat_after_rst", lat, 4, 6);
        esp_req = 1'b0;
        wait_ack(1'b0, 20, lat);
        chk_range("ack_fall_lat", lat, 2, 4);

        // Select 10 then request.
        esp_sel = 4'd10;
        for (int i = 0; i < 3; i++) step();
        esp_req = 1'b1;
        wait_ack(1'b1, 20, lat);
        chk_range("ack_lat_sel10", lat, 4, 6);
        chk("sel_at_ack", {28'd0, sel_q}, 32'd10);

        // Select changes while acked must be ignored.
        esp_sel = 4'd3;
        for (int i = 0; i < 4; i++) step();
        chk("sel_hold", {28'd0, sel_q}, 32'd10);
        esp_req = 1'b0;
        wait_ack(1'b0, 20, lat);
        chk_range("ack_fall_lat2", lat, 2, 4);
        step();
        esp_req = 1'b1;
        wait_ack(1'b1, 20, lat);
        chk("sel_new", {28'd0, sel_q}, 32'd3);
        esp_req = 1'b0;
        wait_ack(1'b0, 20, lat);

        // Short request aborts in the settle window.
        esp_sel = 4'd7;
        for (int i = 0; i < 3; i++) step();
        esp_req = 1'b1;
        for (int i = 0; i < 3; i++) step();
        esp_req = 1'b0;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (esp_ack === 1'b1) saw = 1;
        end
        chk("abort_no_ack", saw, 32'd0);
        chk("abort_sel", {28'd0, sel_q}, 32'd7);

        // Bouncing switch 5.
        ch = 16'h0000;
        for (int i = 0; i < 10; i++) step();
        saw = 0;
        ch[5] = 1'b1; step(); if (ch_clean[5]) saw = 1; step(); if (ch_clean[5]) saw = 1;
        ch[5] = 1'b0; step(); if (ch_clean[5]) saw = 1; step(); if (ch_clean[5]) saw = 1;
        ch[5] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (lat < 0 && ch_clean[5] === 1'b1) lat = i;
        end
`ifdef ESP_QUERY_DEBOUNCE_EN
        chk("db_quiet_while_bouncing", saw, 32'd0);
        chk_range("db_rise_lat", lat, 6, 6);
`else
        chk_range("nodb_rise_lat", lat, 3, 3);
`endif

        // Reset during ACK.
        esp_sel = 4'd9;
        for (int i = 0; i < 3; i++) step();
        esp_req = 1'b1;
        wait_ack(1'b1, 20, lat);
        chk("pre_rst_sel", {28'd0, sel_q}, 32'd9);
        reset = 1'b1;
        #1;
        m_clear();
        chk("midack_rst_ack", {31'd0, esp_ack}, 32'd0);
        chk("midack_rst_sel", {28'd0, sel_q}, 32'd0);
        @(negedge clk);
        step();
        step();
        esp_req = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic with alternating bouncy and quiet switch phases.
        bounce_mode = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ((n % 64) == 0) bounce_mode = ~bounce_mode;
            if ($urandom_range(0, 3) == 0) esp_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) esp_req = ~esp_req;
            for (int b = 0; b < 16; b++) begin
                if (bounce_mode) begin
                    if ($urandom_range(0, 3) == 0) ch[b] = ~ch[b];
                end else begin
                    if ($urandom_range(0, 63) == 0) ch[b] = ~ch[b];
                end
            end
            if (n == 1500) begin
                reset = 1'b1;
                #1;
                m_clear();
                chk("rand_rst_ack", {31'd0, esp_ack}, 32'd0);
                @(negedge clk);
                step();
                reset = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
